// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU definitions: shared-memory geometry and arbiter FSM states
//
// Contents:
//   N_CORES          default number of cores on the shared memory
//   SM_AW / SM_DW    shared-memory address / data width
//   smem_arb_state_t shared-memory arbiter FSM state encoding
package gpu_pkg;

    localparam int N_CORES = 8;
    localparam int SM_AW   = 12;
    localparam int SM_DW   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } smem_arb_state_t;

endpackage

// File: rtl/smem_arbiter_if.sv
// rtl/smem_arbiter_if.sv - core-array and SRAM-port bundle of the shared-memory arbiter
//
// Signals:
//   req/we/addr/wdata   per-core request, store flag, address, store data (packed, core k at k*AW / k*DW)
//   val_data/rdata      one-hot acknowledge and broadcast load data back to the cores
//   sm_en/sm_we/sm_addr/sm_wdata/sm_rdata   single-port SRAM macro port
// Modports:
//   slave   the arbiter's view
//   master  the surrounding environment (cores + SRAM)
interface smem_arbiter_if
    import gpu_pkg::*;
#(
    parameter int N_CORES = gpu_pkg::N_CORES,
    parameter int AW      = SM_AW,
    parameter int DW      = SM_DW
);

    logic [N_CORES-1:0]    req;
    logic [N_CORES-1:0]    we;
    logic [N_CORES*AW-1:0] addr;
    logic [N_CORES*DW-1:0] wdata;
    logic [N_CORES-1:0]    val_data;
    logic [DW-1:0]         rdata;

    logic                  sm_en;
    logic                  sm_we;
    logic [AW-1:0]         sm_addr;
    logic [DW-1:0]         sm_wdata;
    logic [DW-1:0]         sm_rdata;

    modport slave (
        input  req, we, addr, wdata, sm_rdata,
        output val_data, rdata, sm_en, sm_we, sm_addr, sm_wdata
    );

    modport master (
        output req, we, addr, wdata, sm_rdata,
        input  val_data, rdata, sm_en, sm_we, sm_addr, sm_wdata
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker
//
// Ports:
//   req_eff  in  N         candidate requests (already masked by the caller)
//   ptr      in  clog2(N)  highest-priority index this cycle
//   gnt_id   out clog2(N)  first set bit at or above ptr, wrapping modulo N
//   any      out 1         at least one candidate present
// N must be a power of two so the index arithmetic wraps naturally.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_eff,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    // Walk offsets from the far end back towards ptr so the last hit, which
    // is the one closest to ptr, is the one that sticks.
    always_comb begin
        gnt_id = '0;
        any    = |req_eff;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_eff[ptr + IW'(i)]) begin
                gnt_id = ptr + IW'(i);
            end
        end
    end

endmodule

// File: rtl/smem_arbiter.sv
// rtl/smem_arbiter.sv - round-robin arbiter sharing one single-port SRAM among the cores
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   bus       slave modport of smem_arbiter_if (core requests/acks, SRAM port)
//   busy      out  an access is in flight (FSM not in IDLE)
//   grant_id  out  index of the current or most recently granted core
// Parameters:
//   N_CORES   requesting cores, power of two 2..16
//   AW / DW   SRAM address / data width
//   MEM_LAT   SRAM read latency in cycles (>= 1)
module smem_arbiter
    import gpu_pkg::*;
#(
    parameter int N_CORES = gpu_pkg::N_CORES,
    parameter int AW      = SM_AW,
    parameter int DW      = SM_DW,
    parameter int MEM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    smem_arbiter_if.slave              bus,
    output logic                       busy,
    output logic [$clog2(N_CORES)-1:0] grant_id
);

    localparam int IW = $clog2(N_CORES);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
    localparam logic [N_CORES-1:0] ONE = {{(N_CORES-1){1'b0}}, 1'b1};

    smem_arb_state_t    state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [N_CORES-1:0] mask_q, mask_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [LW-1:0]      lat_q, lat_d;

    logic [N_CORES-1:0] req_eff;
    logic [IW-1:0]      pick_id;
    logic               pick_any;

    // A core sees its val_data and needs one edge to drop req, so the core
    // just served is hidden for the first IDLE cycle to avoid a double grant.
    assign req_eff = bus.req & ~mask_q;

    rr_pick #(
        .N  (N_CORES),
        .IW (IW)
    ) u_pick (
        .req_eff (req_eff),
        .ptr     (ptr_q),
        .gnt_id  (pick_id),
        .any     (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        mask_d  = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;

        unique case (state_q)
            IDLE: begin
                // Request fields are captured here so the cores may change
                // them freely while the access is in flight.
                if (pick_any) begin
                    id_d    = pick_id;
                    we_d    = bus.we[pick_id];
                    addr_d  = bus.addr[pick_id*AW +: AW];
                    wdata_d = bus.wdata[pick_id*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    // Stores leave the last load result on rdata untouched.
                    if (!we_q) begin
                        rdata_d = bus.sm_rdata;
                    end
                    state_d = ACK;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ACK: begin
                ptr_d   = id_q + IW'(1);
                mask_d  = ONE << id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The SRAM port is held at zero outside ISSUE so nothing reaches the
    // macro unless an access is actually being issued.
    assign bus.sm_en    = (state_q == ISSUE);
    assign bus.sm_we    = (state_q == ISSUE) && we_q;
    assign bus.sm_addr  = (state_q == ISSUE) ? addr_q : '0;
    assign bus.sm_wdata = (state_q == ISSUE) ? wdata_q : '0;

    assign bus.val_data = (state_q == ACK) ? (ONE << id_q) : '0;
    assign bus.rdata    = rdata_q;

    assign busy     = (state_q != IDLE);
    assign grant_id = id_q;

endmodule

// File: tb/tb_smem_arbiter.sv
// tb/tb_smem_arbiter.sv - self-checking bench for smem_arbiter
module tb_smem_arbiter;
    import gpu_pkg::*;

    localparam int N       = 8;
    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int MEM_LAT = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [2:0] grant_id;

    smem_arbiter_if #(.N_CORES(N), .AW(AW), .DW(DW)) bus ();

    smem_arbiter #(
        .N_CORES (N),
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    // SRAM model, read latency 1
    logic [7:0] sram [4096];
    logic [7:0] sram_rd;
    logic       sram_init;

    function automatic logic [7:0] pat(input logic [11:0] a);
        if (a == 12'h123) return 8'h5A;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 4096; i++) sram[i] <= pat(12'(i));
            sram_rd <= 8'h00;
        end else if (bus.sm_en) begin
            if (bus.sm_we) sram[bus.sm_addr] <= bus.sm_wdata;
            sram_rd <= sram[bus.sm_addr];
        end
    end
    assign bus.sm_rdata = sram_rd;

    // scoreboard state
    typedef struct packed {logic we; logic [11:0] addr; logic [7:0] wdata;} iss_t;
    typedef struct packed {logic [7:0] val; logic [7:0] rdata;} ack_t;
    typedef struct {int core; logic we; logic [11:0] addr; logic [7:0] wdata;
                    logic [7:0] exp_val; logic [7:0] exp_rdata;} vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    iss_t       iss_q[$];
    ack_t       ack_q[$];
    int         ack_cycs[$];
    int         grant_log[$];
    logic [7:0] ref_mem [4096];
    logic [7:0] model_rdata;
    int         ptr_m;
    int         remaining[N];
    int         linger[N];
    int         rr_counts[N];
    logic       core_we[N];
    logic [11:0] core_addr[N];
    logic [7:0] core_wdata[N];
    int         issue_cyc, ack_cyc;
    logic       prev_sm_en;
    logic       saw_issue;
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic update_drive();
        for (int k = 0; k < N; k++) begin
            bus.we[k] = core_we[k];
            bus.addr[k*AW +: AW] = core_addr[k];
            bus.wdata[k*DW +: DW] = core_wdata[k];
            if (remaining[k] > 0) begin
                bus.req[k] = 1'b1;
            end else if (linger[k] > 0) begin
                bus.req[k] = 1'b1;
                linger[k]--;
            end else begin
                bus.req[k] = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        iss_t ei;
        ack_t ea;
        saw_issue = 1'b0;
        if (bus.sm_en) begin
            saw_issue = 1'b1;
            issue_cyc = cyc;
            chk("no_back_to_back", prev_sm_en, 0);
            if (iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got access to 0x%0h, want none", bus.sm_addr);
            end else begin
                ei = iss_q.pop_front();
                chk("issue", {bus.sm_we, bus.sm_addr, bus.sm_we ? bus.sm_wdata : 8'h00}, ei);
            end
        end
        prev_sm_en = bus.sm_en;
        if (bus.val_data != '0) begin
            ack_cyc = cyc;
            ack_cycs.push_back(cyc);
            chk("val_onehot", $countones(bus.val_data), 1);
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got val_data 0x%0h, want none", bus.val_data);
            end else begin
                ea = ack_q.pop_front();
                chk("ack_val", bus.val_data, ea.val);
                chk("ack_rdata", bus.rdata, ea.rdata);
            end
            for (int k = 0; k < N; k++) begin
                if (bus.val_data[k]) begin
                    grant_log.push_back(k);
                    if (remaining[k] > 0) remaining[k]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        update_drive();
        @(negedge clk);
        monitor();
    endtask

    function automatic bit any_remaining();
        for (int k = 0; k < N; k++) if (remaining[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic flush();
        iss_q.delete();
        ack_q.delete();
        for (int k = 0; k < N; k++) begin
            remaining[k] = 0;
            linger[k] = 0;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((iss_q.size() != 0 || ack_q.size() != 0 || any_remaining()) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending acks after %0d cycles, want 0", name, ack_q.size(), budget);
            flush();
        end
        repeat (3) tick();
    endtask

    task automatic push_acc(input int core, input logic we, input logic [11:0] a, input logic [7:0] d,
                            input bit have_exp, input logic [7:0] exp_val, input logic [7:0] exp_rd);
        iss_q.push_back({we, a, we ? d : 8'h00});
        if (we) ref_mem[a] = d;
        else    model_rdata = ref_mem[a];
        if (have_exp) ack_q.push_back({exp_val, exp_rd});
        else          ack_q.push_back({8'(1 << core), model_rdata});
        ptr_m = (core + 1) % N;
    endtask

    task automatic launch_one(input int core, input logic we, input logic [11:0] a, input logic [7:0] d,
                              input bit have_exp, input logic [7:0] exp_val, input logic [7:0] exp_rd);
        core_we[core] = we;
        core_addr[core] = a;
        core_wdata[core] = d;
        remaining[core]++;
        push_acc(core, we, a, d, have_exp, exp_val, exp_rd);
    endtask

    // cores keep requesting until served rr_counts[k] times; the expected
    // grant order comes from a round-robin reference walk
    task automatic launch_rr();
        int rem[N];
        int total = 0;
        int p = ptr_m;
        int g;
        for (int k = 0; k < N; k++) begin
            rem[k] = rr_counts[k];
            total += rr_counts[k];
            remaining[k] = rr_counts[k];
        end
        for (int t = 0; t < total; t++) begin
            g = -1;
            for (int o = 0; o < N && g < 0; o++) begin
                if (rem[(p + o) % N] > 0) g = (p + o) % N;
            end
            push_acc(g, core_we[g], core_addr[g], core_wdata[g], 1'b0, 8'h00, 8'h00);
            rem[g]--;
            p = (g + 1) % N;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        flush();
        model_rdata = 8'h00;
        ptr_m = 0;
        prev_sm_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!saw_issue && n < 10);
        if (!saw_issue) begin
            checks++;
            errors++;
            $display("FAIL %s_issue_timeout: got no sm_en in %0d cycles, want one", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1);
    end

    initial begin
        int l;
        logic [7:0] seen;

        reset = 1'b1;
        sram_init = 1'b1;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        model_rdata = 8'h00;
        ptr_m = 0;
        prev_sm_en = 1'b0;
        saw_issue = 1'b0;
        issue_cyc = 0;
        ack_cyc = 0;
        for (int k = 0; k < N; k++) begin
            remaining[k] = 0;
            linger[k] = 0;
            rr_counts[k] = 0;
            core_we[k] = 1'b0;
            core_addr[k] = '0;
            core_wdata[k] = '0;
        end
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));

        vecs[0] = '{0, 1'b1, 12'h000, 8'hA5, 8'h01, 8'h5A};
        vecs[1] = '{0, 1'b0, 12'h000, 8'h00, 8'h01, 8'hA5};
        vecs[2] = '{7, 1'b1, 12'hFFF, 8'h00, 8'h80, 8'hA5};
        vecs[3] = '{7, 1'b0, 12'hFFF, 8'h00, 8'h80, 8'h00};
        vecs[4] = '{4, 1'b1, 12'h800, 8'hFF, 8'h10, 8'h00};
        vecs[5] = '{1, 1'b0, 12'h800, 8'h00, 8'h02, 8'hFF};
        vecs[6] = '{6, 1'b1, 12'h7FF, 8'h3C, 8'h40, 8'hFF};
        vecs[7] = '{3, 1'b0, 12'h7FF, 8'h00, 8'h08, 8'h3C};

        repeat (2) @(posedge clk);
        #1;
        sram_init = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_val_data", bus.val_data, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_sm_en", bus.sm_en, 0);
        chk("rst_sm_we", bus.sm_we, 0);
        chk("rst_sm_addr", bus.sm_addr, 0);
        chk("rst_sm_wdata", bus.sm_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        do_reset();

        // contention from reset: 0, 3, 7
        core_addr[0] = 12'h010;
        core_addr[3] = 12'h020;
        core_addr[7] = 12'h030;
        rr_counts[0] = 1;
        rr_counts[3] = 1;
        rr_counts[7] = 1;
        ack_cycs.delete();
        grant_log.delete();
        launch_rr();
        drain(60, "contention");
        chk("contention_acks", ack_cycs.size(), 3);
        chk("contention_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0]}, 12'h037);
        chk("contention_gap01", ack_cycs[1] - ack_cycs[0], 4);
        chk("contention_gap12", ack_cycs[2] - ack_cycs[1], 4);
        for (int k = 0; k < N; k++) rr_counts[k] = 0;

        // single load, latency
        do_reset();
        launch_one(2, 1'b0, 12'h123, 8'h00, 1'b1, 8'h04, 8'h5A);
        tick();
        l = cyc;
        drain(20, "single_load");
        chk("load_issue_latency", issue_cyc - l, 1);
        chk("load_ack_latency", ack_cyc - l, 2 + MEM_LAT);
        chk("load_grant_id", grant_id, 2);
        chk("load_idle_busy", busy, 0);

        // table of single transactions
        for (int v = 0; v < 8; v++) begin
            launch_one(vecs[v].core, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                       1'b1, vecs[v].exp_val, vecs[v].exp_rdata);
            drain(20, "vector");
        end

        // store then load by core 5 at the top address
        launch_one(5, 1'b1, 12'hFFF, 8'hC3, 1'b1, 8'h20, 8'h3C);
        drain(20, "store5");
        launch_one(5, 1'b0, 12'hFFF, 8'h00, 1'b1, 8'h20, 8'hC3);
        drain(20, "load5");
        chk("store5_mem", sram[12'hFFF], 8'hC3);

        // fairness with ptr at 6, 20 grants
        for (int k = 0; k < N; k++) begin
            core_we[k] = 1'b0;
            core_addr[k] = 12'((k << 8) + 5);
            rr_counts[k] = (k >= 2 && k <= 5) ? 2 : 3;
        end
        grant_log.delete();
        launch_rr();
        drain(200, "fairness");
        chk("fair_count", grant_log.size(), 20);
        chk("fair_first", grant_log[0], 6);
        for (int i = 0; i + 8 <= grant_log.size(); i++) begin
            seen = 8'h00;
            for (int j = 0; j < 8; j++) seen[grant_log[i+j]] = 1'b1;
            chk("fair_window", $countones(seen), 8);
        end
        for (int k = 0; k < N; k++) rr_counts[k] = 0;

        // mask: core 1 lingers one cycle after its ack while core 4 requests
        launch_one(0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 8'h00);
        drain(20, "mask_pre");
        core_addr[1] = 12'h800;
        core_addr[4] = 12'h7FF;
        core_we[1] = 1'b0;
        core_we[4] = 1'b0;
        rr_counts[1] = 1;
        rr_counts[4] = 1;
        linger[1] = 1;
        grant_log.delete();
        launch_rr();
        drain(40, "mask_pair");
        chk("mask_pair_order", {grant_log[0][3:0], grant_log[1][3:0]}, 8'h14);
        for (int k = 0; k < N; k++) rr_counts[k] = 0;

        // mask: core 1 alone lingering must not be granted twice
        ack_cycs.delete();
        launch_one(1, 1'b0, 12'h800, 8'h00, 1'b1, 8'h02, 8'hFF);
        linger[1] = 1;
        drain(20, "mask_alone");
        chk("mask_alone_grants", ack_cycs.size(), 1);

        // reset during WAIT of a load by core 3
        ack_cycs.delete();
        launch_one(3, 1'b0, 12'h7FF, 8'h00, 1'b0, 8'h00, 8'h00);
        wait_issue("rst_wait");
        tick();
        chk("rst_wait_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_wait_val", bus.val_data, 0);
        chk("rst_wait_rdata", bus.rdata, 0);
        chk("rst_wait_sm_en", bus.sm_en, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_grant_id", grant_id, 0);
        do_reset();
        repeat (5) tick();
        chk("rst_wait_no_ack", ack_cycs.size(), 0);

        // ptr restarted at 0: cores 1 and 7 together give 1 first
        core_addr[1] = 12'h100;
        core_addr[7] = 12'h700;
        rr_counts[1] = 1;
        rr_counts[7] = 1;
        grant_log.delete();
        launch_rr();
        drain(40, "rst_ptr");
        chk("rst_ptr_order", {grant_log[0][3:0], grant_log[1][3:0]}, 8'h17);
        for (int k = 0; k < N; k++) rr_counts[k] = 0;

        // reset during ISSUE of a store: the SRAM must stay untouched
        launch_one(6, 1'b1, 12'h050, 8'h77, 1'b0, 8'h00, 8'h00);
        wait_issue("rst_issue");
        reset = 1'b1;
        #1;
        chk("rst_issue_sm_en", bus.sm_en, 0);
        do_reset();
        ref_mem[12'h050] = 8'h6C;
        repeat (2) tick();
        chk("rst_issue_no_write", sram[12'h050], 8'h6C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
